// File: rtl/alu8_regfile_pipe.sv
// Two-stage 8-bit ALU core: stage 1 fetches operands from a 16x8 register bank,
// stage 2 computes, writes back to the bank and stores every result in a 256x8 memory.
module alu8_regfile_pipe (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [3:0] addr1,
    input  logic [3:0] addr2,
    input  logic [3:0] rd,
    input  logic [2:0] func,
    input  logic [7:0] memaddr,
    input  logic       write,
    output logic [7:0] Zout,
    output logic       carry_borrow,
    input  logic [3:0] dbg_reg_addr,
    output logic [7:0] dbg_reg_data,
    input  logic [7:0] dbg_mem_addr,
    output logic [7:0] dbg_mem_data
);

    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_SUB  = 3'd1,
        FN_AND  = 3'd2,
        FN_OR   = 3'd3,
        FN_XOR  = 3'd4,
        FN_NOTA = 3'd5,
        FN_NOTB = 3'd6,
        FN_INCA = 3'd7
    } func_e;

    logic [7:0] regbank_q [16];
    logic [7:0] mem_q     [256];

    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] rd_q;
    func_e      func_q;
    logic [7:0] memaddr_q;
    logic       write_q;
    logic       valid_q;
    logic [7:0] zout_q;
    logic       carry_q;

    logic [8:0] wide_d;
    logic [7:0] res_d;
    logic       carry_d;

    // Bit 8 of the 9-bit result is the carry for ADD/INC and the borrow for SUB.
    always_comb begin
        wide_d = 9'd0;
        case (func_q)
            FN_ADD:  wide_d = {1'b0, a_q} + {1'b0, b_q};
            FN_SUB:  wide_d = {1'b0, a_q} - {1'b0, b_q};
            FN_AND:  wide_d = {1'b0, a_q & b_q};
            FN_OR:   wide_d = {1'b0, a_q | b_q};
            FN_XOR:  wide_d = {1'b0, a_q ^ b_q};
            FN_NOTA: wide_d = {1'b0, ~a_q};
            FN_NOTB: wide_d = {1'b0, ~b_q};
            FN_INCA: wide_d = {1'b0, a_q} + 9'd1;
            default: wide_d = 9'd0;
        endcase
    end

    assign res_d   = wide_d[7:0];
    assign carry_d = wide_d[8];

    // Operand reads and write-back share an edge, so a read of the register
    // being written sees the old value (no forwarding).
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            rd_q      <= 4'd0;
            func_q    <= FN_ADD;
            memaddr_q <= 8'd0;
            write_q   <= 1'b0;
            valid_q   <= 1'b0;
            zout_q    <= 8'd0;
            carry_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regbank_q[i] <= 8'(i);
            end
        end else begin
            a_q       <= regbank_q[addr1];
            b_q       <= regbank_q[addr2];
            rd_q      <= rd;
            func_q    <= func_e'(func);
            memaddr_q <= memaddr;
            write_q   <= write;
            valid_q   <= 1'b1;
            if (valid_q) begin
                zout_q  <= res_d;
                carry_q <= carry_d;
                if (write_q) begin
                    regbank_q[rd_q] <= res_d;
                end
            end
        end
    end

    // Result memory has no reset; valid_q is cleared asynchronously so an
    // in-flight operation never lands after reset.
    always_ff @(posedge clk1) begin
        if (valid_q) begin
            mem_q[memaddr_q] <= res_d;
        end
    end

    assign Zout         = zout_q;
    assign carry_borrow = carry_q;
    assign dbg_reg_data = regbank_q[dbg_reg_addr];
    assign dbg_mem_data = mem_q[dbg_mem_addr];

endmodule

// File: tb/tb_alu8_regfile_pipe.sv
// Randomised and directed bench for alu8_regfile_pipe against a transaction-level
// model: each issued op reads the model bank at issue and retires one edge later.
`timescale 1ns/100ps
module tb_alu8_regfile_pipe;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] addr1 = '0, addr2 = '0, rd = '0;
    logic [2:0] func = '0;
    logic [7:0] memaddr = '0;
    logic       write = 1'b0;
    logic [7:0] Zout;
    logic       carry_borrow;
    logic [3:0] dbg_reg_addr = '0;
    logic [7:0] dbg_reg_data;
    logic [7:0] dbg_mem_addr = '0;
    logic [7:0] dbg_mem_data;

    alu8_regfile_pipe dut (
        .clk1(clk1), .rst_n(rst_n),
        .addr1(addr1), .addr2(addr2), .rd(rd), .func(func),
        .memaddr(memaddr), .write(write),
        .Zout(Zout), .carry_borrow(carry_borrow),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int   r;
        int   c;
        int   rd;
        int   ma;
        bit   w;
    } op_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mregs [16];
    int   mmem  [256];
    bit   mmem_ok [256];
    op_t  pend;
    bit   pend_valid = 0;
    int   exp_z = 0;
    int   exp_c = 0;
    int   last_ma = -1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Spec-level reference: integer arithmetic, carry/borrow from the rules.
    function automatic void ref_alu(input int f, input int a, input int b,
                                    output int r, output int c);
        c = 0;
        case (f)
            0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = 255 - b;
            default: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
        endcase
    endfunction

    // Issue one op on the coming edge; entered and left just after a negedge.
    task automatic step(input int a1, input int a2, input int rdv, input int f,
                        input int ma, input bit w);
        op_t nxt;
        addr1 = 4'(a1); addr2 = 4'(a2); rd = 4'(rdv);
        func = 3'(f); memaddr = 8'(ma); write = w;
        dbg_reg_addr = 4'($urandom_range(0, 15));
        if (pend_valid) dbg_mem_addr = 8'(pend.ma);
        @(posedge clk1);
        ref_alu(f, mregs[a1], mregs[a2], nxt.r, nxt.c);
        nxt.rd = rdv; nxt.ma = ma; nxt.w = w;
        if (pend_valid) begin
            exp_z = pend.r;
            exp_c = pend.c;
            if (pend.w) mregs[pend.rd] = pend.r;
            mmem[pend.ma] = pend.r;
            mmem_ok[pend.ma] = 1;
            last_ma = pend.ma;
        end else begin
            last_ma = -1;
        end
        pend = nxt;
        pend_valid = 1;
        #1;
        $display("op f=%0d a1=%0d a2=%0d rd=%0d ma=%0d w=%0d -> Zout=%0d C=%0d",
                 f, a1, a2, rdv, ma, w, Zout, carry_borrow);
        check_eq("zout", int'(Zout), exp_z);
        check_eq("carry", int'(carry_borrow), exp_c);
        check_eq("dbg_reg", int'(dbg_reg_data), mregs[dbg_reg_addr]);
        if (last_ma >= 0) check_eq("dbg_mem", int'(dbg_mem_data), mmem[last_ma]);
        @(negedge clk1);
    endtask

    task automatic step2(input int a1, input int a2, input int rdv, input int f,
                         input int ma, input bit w);
        step(a1, a2, rdv, f, ma, w);
        step(a1, a2, rdv, f, ma, w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        $display("reset asserted -> Zout=%0d C=%0d", Zout, carry_borrow);
        check_eq("rst_zout", int'(Zout), 0);
        check_eq("rst_carry", int'(carry_borrow), 0);
        for (int i = 0; i < 16; i++) mregs[i] = i;
        pend_valid = 0;
        exp_z = 0;
        exp_c = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_reg_addr = 4'(i);
            #1;
            check_eq("rst_reg", int'(dbg_reg_data), mregs[i]);
        end
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic peek_reg(input string tag, input int a, input int exp);
        dbg_reg_addr = 4'(a);
        #1;
        check_eq(tag, int'(dbg_reg_data), exp);
    endtask

    task automatic peek_mem(input string tag, input int a, input int exp);
        dbg_mem_addr = 8'(a);
        #1;
        check_eq(tag, int'(dbg_mem_data), exp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mmem[i] = 0; mmem_ok[i] = 0; end
        @(negedge clk1);
        do_reset();

        // ADD 3+5 into r10 / mem[225]
        step2(3, 5, 10, 0, 225, 1);
        check_eq("add_z", int'(Zout), 8);
        check_eq("add_c", int'(carry_borrow), 0);
        peek_reg("add_r10", 10, 8);
        peek_mem("add_m225", 225, 8);

        do_reset();
        step2(3, 5, 14, 1, 226, 1);
        check_eq("sub_z", int'(Zout), 254);
        check_eq("sub_c", int'(carry_borrow), 1);
        step2(10, 5, 0, 1, 227, 0);
        check_eq("sub2_z", int'(Zout), 5);
        check_eq("sub2_c", int'(carry_borrow), 0);

        do_reset();
        step2(3, 8, 0, 2, 10, 0);  check_eq("and_z", int'(Zout), 0);
        step2(7, 3, 0, 3, 11, 0);  check_eq("or_z", int'(Zout), 7);
        step2(10, 5, 0, 4, 12, 0); check_eq("xor_z", int'(Zout), 15);
        step2(12, 0, 0, 5, 13, 0); check_eq("nota_z", int'(Zout), 243);
        step2(0, 13, 0, 6, 14, 0); check_eq("notb_z", int'(Zout), 242);
        check_eq("logic_c", int'(carry_borrow), 0);

        // INC wrap: r9 <- ~r0 = 255, then INC r9
        step2(0, 0, 9, 6, 20, 1);
        step2(9, 0, 0, 7, 21, 0);
        check_eq("inc_wrap_z", int'(Zout), 0);
        check_eq("inc_wrap_c", int'(carry_borrow), 1);
        step2(11, 0, 0, 7, 22, 0);
        check_eq("inc_z", int'(Zout), 12);
        check_eq("inc_c", int'(carry_borrow), 0);

        // Read-after-write hazard: no forwarding
        do_reset();
        step(3, 5, 10, 0, 30, 1);
        step(10, 0, 1, 0, 31, 0);
        step(10, 0, 2, 0, 32, 0);
        check_eq("haz_old", int'(Zout), 10);
        step(0, 0, 3, 2, 33, 0);
        check_eq("haz_new", int'(Zout), 8);

        // write=0, then reset with an op in flight
        do_reset();
        step(3, 8, 0, 2, 50, 0);
        step(3, 5, 4, 0, 100, 0);
        step(3, 5, 10, 0, 50, 1);
        check_eq("nw_z", int'(Zout), 8);
        peek_reg("nw_r4", 4, 4);
        peek_mem("nw_m100", 100, 8);
        do_reset();
        peek_mem("rst_m50", 50, 0);
        peek_reg("rst_r10", 10, 10);

        // Random traffic with occasional mid-pipeline reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu8_regfile_pipe.md
Name: alu8_regfile_pipe

Overview:
- 8-bit, 8-function ALU with a 16x8 register bank and a 256x8 result memory, organised as a two-stage pipeline on one clock.
- Stage 1 fetches two operands from the register bank. Stage 2 computes the result, drives Zout and carry_borrow, writes the result back to the register bank (when enabled) and stores it in memory.
- Used as the datapath/ALU core; debug read ports give benches visibility of the register bank and memory.

Parameters:
- none (widths fixed: data 8, register address 4, memory address 8, func 3)

Ports:
- clk1  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- addr1  input  4  register index of operand A
- addr2  input  4  register index of operand B
- rd  input  4  destination register index for write-back
- func  input  3  operation select
- memaddr  input  8  memory address where the result is stored
- write  input  1  1 = write result to regbank[rd]
- Zout  output  8  registered ALU result
- carry_borrow  output  1  registered carry/borrow flag
- dbg_reg_addr  input  4  debug register read index
- dbg_reg_data  output  8  combinational regbank[dbg_reg_addr]
- dbg_mem_addr  input  8  debug memory read address
- dbg_mem_data  output  8  combinational mem[dbg_mem_addr]

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Zout=0, carry_borrow=0.
  - All stage-1 registers (A, B, rd, func, memaddr, write) cleared.
  - Stage-2 valid flag cleared.
  - regbank[i]=i for i=0..15.
  - mem is not reset (contents undefined until written).
- Stage 1, every rising edge with rst_n=1:
  - A <= regbank[addr1], B <= regbank[addr2].
  - Latch rd, func, memaddr and write.
  - Set valid=1.
- Stage 2, rising edge when valid=1:
  - Zout <= R and carry_borrow <= C.
  - If the stage-1 write flag is 1, regbank[rd] <= R.
  - mem[memaddr] <= R unconditionally.
- Latency: inputs applied before edge N produce Zout/carry_borrow, register and memory updates at edge N+1. Throughput is one operation per cycle.
- Functions (R 8-bit, arithmetic modulo 256):
  - 0 ADD: R=A+B, C=carry out of bit 7
  - 1 SUB: R=A-B, C=1 if A<B (borrow), else 0
  - 2 AND: R=A&B, C=0
  - 3 OR: R=A|B, C=0
  - 4 XOR: R=A^B, C=0
  - 5 NOT A: R=~A, C=0
  - 6 NOT B: R=~B, C=0
  - 7 INC A: R=A+1, C=1 only when A=255
- Hazards:
  - No forwarding.
  - A stage-1 read at the same edge as a stage-2 write to the same register samples the OLD value.
  - The new value is visible to reads at the following edge.
- Same-edge register writes: only stage 2 writes the regbank, so there is no write conflict.
- Debug ports:
  - Purely combinational reads.
  - Reflect writes immediately after the write edge.
  - Do not disturb pipeline state.
- Reset asserted mid-operation:
  - In-flight operation discarded; no register or memory write occurs.
  - Outputs are 0 until the first valid stage-2 edge after release.

Test Plan:
- Reset, then ADD addr1=3,addr2=5,rd=10,memaddr=225,write=1, held for 2 edges -> Zout=8, carry_borrow=0, dbg regbank[10]=8, mem[225]=8.
- After reset, SUB addr1=3,addr2=5,rd=14,memaddr=226,write=1 -> Zout=254, carry_borrow=1. Separately, SUB 10-5 -> Zout=5, carry_borrow=0.
- After reset, logic ops held 2 edges each -> carry_borrow=0 every time:
  - AND 3&8 -> Zout=0
  - OR 7|3 -> Zout=7
  - XOR 10^5 -> Zout=15
  - NOT A of regbank[12] -> Zout=243
  - NOT B of regbank[13] -> Zout=242
- NOT B of reg0 into rd=9 (reg9=255); then INC A addr1=9 -> Zout=0, carry_borrow=1. INC A of reg11 -> Zout=12, carry_borrow=0.
- Back-to-back ADD rd=10 (3+5) followed next cycle by ADD addr1=10,addr2=0 -> second result 10 (old value); a third op issued one cycle later reading reg10 -> 8.
- ADD with write=0,rd=4,memaddr=100 -> regbank[4] stays 4, mem[100]=8. Then assert rst_n=0 mid-pipeline -> Zout=0, carry_borrow=0 immediately, regbank[10]=10, no memory write for the in-flight op.
